// File: rtl/dma_desc_scheduler.sv
//------------------------------------------------------------------------------
// Module  : dma_desc_scheduler
// Purpose : Per-channel descriptor queues with an arbiter and an engine
//           handshake FSM. The FSM issues one descriptor at a time.
// Config  : DMA_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
//           Without it, arbitration is round-robin.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dma_desc_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
  } dma_desc_t;
endpackage

module dma_desc_scheduler
  import dma_desc_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_valid,
  input  logic [1:0]              push_ch,
  input  dma_desc_t               push_desc,
  output logic [NUM_CHANNELS-1:0] push_ready,
  input  logic [NUM_CHANNELS-1:0] ch_enable,
  output logic                    eng_start,
  output logic [1:0]              eng_channel_sel,
  output dma_desc_t               eng_descriptor,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  input  logic                    eng_error,
  output logic [NUM_CHANNELS-1:0] ch_done,
  output logic [NUM_CHANNELS-1:0] ch_err,
  input  logic [NUM_CHANNELS-1:0] irq_clr,
  output logic                    irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  dma_desc_t               mem_q    [NUM_CHANNELS][FIFO_DEPTH];
  dma_desc_t               mem_d    [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr_q [NUM_CHANNELS];
  logic [PTR_W:0]          wr_ptr_d [NUM_CHANNELS];
  logic [PTR_W:0]          rd_ptr_q [NUM_CHANNELS];
  logic [PTR_W:0]          rd_ptr_d [NUM_CHANNELS];
  logic [1:0]              sel_q, sel_d;
  dma_desc_t               desc_q, desc_d;
  logic [NUM_CHANNELS-1:0] done_q, done_d;
  logic [NUM_CHANNELS-1:0] err_q, err_d;
  logic                    xfer_err_q, xfer_err_d;
  logic [NUM_CHANNELS-1:0] full, empty, eligible;
  logic                    grant_vld;
  logic [1:0]              grant_ch;
`ifndef DMA_SCHED_FIXED_PRIO_EN
  logic [1:0]              last_q, last_d;
`endif

  // The extra pointer MSB tells a full queue from an empty one.
  genvar c;
  generate
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_status
      assign empty[c]      = (wr_ptr_q[c] == rd_ptr_q[c]);
      assign full[c]       = (wr_ptr_q[c][PTR_W] != rd_ptr_q[c][PTR_W]) &&
                             (wr_ptr_q[c][PTR_W-1:0] == rd_ptr_q[c][PTR_W-1:0]);
      assign push_ready[c] = ~full[c];
    end
  endgenerate

  assign eligible = ~empty & ch_enable;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = 2'd0;
`ifdef DMA_SCHED_FIXED_PRIO_EN
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        grant_ch  = 2'(i);
      end
    end
`else
    // Scan from the farthest channel to the nearest one. The last hit wins,
    // so channel last+1 gets the highest priority.
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      if (eligible[2'(last_q + 2'(i))]) begin
        grant_vld = 1'b1;
        grant_ch  = 2'(last_q + 2'(i));
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sel_d      = sel_q;
    desc_d     = desc_q;
    done_d     = done_q & ~irq_clr;
    err_d      = err_q & ~irq_clr;
    xfer_err_d = xfer_err_q;
    eng_start  = 1'b0;
`ifndef DMA_SCHED_FIXED_PRIO_EN
    last_d     = last_q;
`endif

    if (push_valid && !full[push_ch]) begin
      mem_d[push_ch][wr_ptr_q[push_ch][PTR_W-1:0]] = push_desc;
      wr_ptr_d[push_ch] = wr_ptr_q[push_ch] + (PTR_W+1)'(1);
    end

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          desc_d             = mem_q[grant_ch][rd_ptr_q[grant_ch][PTR_W-1:0]];
          rd_ptr_d[grant_ch] = rd_ptr_q[grant_ch] + (PTR_W+1)'(1);
          sel_d              = grant_ch;
`ifndef DMA_SCHED_FIXED_PRIO_EN
          last_d             = grant_ch;
`endif
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        eng_start = !eng_busy;
        if (!eng_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done) begin
          done_d[sel_q] = 1'b1;
          if (xfer_err_q || eng_error) err_d[sel_q] = 1'b1;
          xfer_err_d = 1'b0;
          state_d    = IDLE;
        end else if (eng_error) begin
          xfer_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      desc_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      xfer_err_q <= 1'b0;
`ifndef DMA_SCHED_FIXED_PRIO_EN
      last_q     <= 2'd3;
`endif
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      desc_q     <= desc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      xfer_err_q <= xfer_err_d;
`ifndef DMA_SCHED_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

  assign eng_channel_sel = sel_q;
  assign eng_descriptor  = desc_q;
  assign ch_done         = done_q;
  assign ch_err          = err_q;
  assign irq             = |{done_q, err_q};

endmodule

`default_nettype wire

// File: doc/dma_desc_scheduler.md
DMA_DESC_SCHEDULER -- requirements
Module: dma_desc_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, the number of DMA channels (fixed at 4; channel index is 2 bits).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, descriptors per channel queue (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port push_valid  input  1  descriptor push request.
REQ-006 The block SHALL have port push_ch  input  2  target channel of push.
REQ-007 The block SHALL have port push_desc  input  dma_desc_t  descriptor to queue.
REQ-008 The block SHALL have port push_ready  output  NUM_CHANNELS  per-channel queue not full.
REQ-009 The block SHALL have port ch_enable  input  NUM_CHANNELS  channel eligible for arbitration.
REQ-010 The block SHALL have port eng_start  output  1  one-cycle start pulse to the DMA engine.
REQ-011 The block SHALL have port eng_channel_sel  output  2  granted channel.
REQ-012 The block SHALL have port eng_descriptor  output  dma_desc_t  descriptor being issued.
REQ-013 The block SHALL have ports eng_busy, eng_done, eng_error  input  1 each  engine status.
REQ-014 The block SHALL have port ch_done  output  NUM_CHANNELS  sticky per-channel completion flag.
REQ-015 The block SHALL have port ch_err  output  NUM_CHANNELS  sticky per-channel error flag.
REQ-016 The block SHALL have port irq_clr  input  NUM_CHANNELS  write-1 clear of ch_done and ch_err.
REQ-017 The block SHALL have port irq  output  1  OR of all ch_done and ch_err bits.

Function
REQ-018 Each channel SHALL hold a FIFO of FIFO_DEPTH descriptors; push_ready[c] = FIFO c not full, with no same-cycle pop bypass.
REQ-019 A push with push_valid=1 and push_ready[push_ch]=1 SHALL enqueue at the clock edge; a push to a full queue SHALL be dropped with no state change.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE.
REQ-021 IDLE: if any channel is nonempty and enabled, arbitrate, pop its head into eng_descriptor, set eng_channel_sel, go to ISSUE; otherwise stay.
REQ-022 Arbitration SHALL be round-robin: search starts at last-granted channel +1 mod 4; the last-granted pointer resets to 3, so channel 0 is searched first.
REQ-023 ISSUE: eng_start = !eng_busy; when eng_start=1, go to WAIT_DONE the next cycle; while eng_busy=1, hold ISSUE with eng_start=0.
REQ-024 eng_start SHALL be high for exactly one cycle per descriptor.
REQ-025 WAIT_DONE: eng_error=1 in any cycle SHALL latch a per-transfer error flag; on eng_done=1, set ch_done[sel], set ch_err[sel] if the flag or eng_error is set, clear the flag, and go to IDLE.
REQ-026 Latency: a push into an empty queue with the FSM in IDLE and the engine idle SHALL produce eng_start two cycles after the push edge.
REQ-027 eng_descriptor and eng_channel_sel SHALL remain stable from ISSUE entry until the return to IDLE.
REQ-028 Deasserting ch_enable SHALL only exclude that channel from the next arbitration; it SHALL NOT abort an in-flight transfer, and the queue is retained.
REQ-029 A same-cycle irq_clr[c] and set of ch_done[c] or ch_err[c] SHALL leave the bit set (set wins).
REQ-030 A same-cycle push to channel c and pop from channel c SHALL both take effect.

Reset
REQ-031 On rst_n low, the block SHALL immediately go to IDLE; all FIFOs SHALL empty; ch_done, ch_err, irq, eng_start, eng_channel_sel, eng_descriptor and the error flag SHALL be 0; push_ready SHALL be all 1.
REQ-032 A reset during WAIT_DONE SHALL discard the in-flight transfer with no ch_done or ch_err set.

Configuration
REQ-033 With macro DMA_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest enabled nonempty channel index wins) and the last-granted pointer SHALL be removed; without it, REQ-022 round-robin applies.

Verification
REQ-034 Reset, then push 1 descriptor to ch2 -> eng_start 2 cycles later, eng_channel_sel=2, eng_descriptor matches; eng_done -> ch_done=4'b0100, irq=1.
REQ-035 Queue 2 descriptors on each of ch0..ch3, all enabled -> grant order 0,1,2,3,0,1,2,3 (fixed-prio build: 0,0,1,1,2,2,3,3).
REQ-036 Push 5 descriptors to ch1 with FIFO_DEPTH=4 -> push_ready[1]=0 after the 4th; the 5th is dropped; exactly 4 starts are issued for ch1.
REQ-037 eng_error pulse mid-transfer on ch3, then eng_done -> ch_err=4'b1000; irq_clr=4'b1000 in the same cycle as a later ch3 done -> ch_done[3] stays 1.
REQ-038 eng_busy held high during ISSUE for 3 cycles -> eng_start=0 for those cycles, then exactly one pulse; ch_enable[0]=0 with ch0 nonempty -> no ch0 grant until it is re-enabled.
